// File: rtl/mul_hilo_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit_pkg
// Shared CPU definitions used by the multiply/HI-LO unit:
//   CPU_WIDTH - datapath width of the core
//   ALU_MUL   - ALU control code that requests a multiply
//   state_t   - multiply unit FSM states
// ---------------------------------------------------------------------------
package mul_hilo_unit_pkg;

   localparam int CPU_WIDTH = 32;

   localparam logic [3:0] ALU_MUL = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // EX-stage helper: true when the decoded ALU operation is a multiply.
   function automatic logic is_mul_op(input logic [3:0] alu_ctrl);
      return alu_ctrl == ALU_MUL;
   endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// ---------------------------------------------------------------------------
// mul_shift_add_core
// Unsigned iterative shift-add multiplier datapath: one multiplier bit per step.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   load           - latch operands, clear accumulator and counter
//   step           - perform one shift-add iteration
//   mcand_in       - unsigned multiplicand
//   mplier_in      - unsigned multiplier
//   product        - 2*WIDTH accumulator (valid after WIDTH steps)
//   last_step      - high while the step in progress is the final one
// ---------------------------------------------------------------------------
module mul_shift_add_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] product,
   output logic               last_step
);

   logic [WIDTH-1:0]   mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;

   // Upper half plus optional multiplicand; the extra bit is the carry that
   // is shifted back into the accumulator MSB.
   always_comb begin
      sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                 (mplier_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      acc_next = {sum, acc_reg[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
      end else if (load) begin
         mcand_reg  <= mcand_in;
         mplier_reg <= mplier_in;
         acc_reg    <= '0;
         cnt_reg    <= '0;
      end else if (step) begin
         acc_reg    <= acc_next;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + 1'b1;
      end
   end

   assign product   = acc_reg;
   assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_hilo_unit.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit
// EX-stage multi-cycle multiplier with HI/LO registers (mult/multu,
// mfhi/mflo, mthi/mtlo). Result lands in HI/LO WIDTH+1 edges after start.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-low reset
//   start_i    - multiply request (ALU control = MUL)
//   signed_i   - 1 = mult (signed), 0 = multu
//   src1_i     - multiplicand (rs)
//   src2_i     - multiplier (rt)
//   hi_we_i    - mthi write enable (honoured only when idle)
//   lo_we_i    - mtlo write enable (honoured only when idle)
//   wdata_i    - mthi/mtlo data
//   busy_o     - high while a multiply is in flight (pipeline stall)
//   done_o     - one-cycle pulse when HI/LO receive a product
//   hi_o, lo_o - HI/LO register contents
// ---------------------------------------------------------------------------
module mul_hilo_unit
   import mul_hilo_unit_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_t             state_reg, state_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               neg_reg, neg_next;
   logic [WIDTH-1:0]   hi_reg, hi_next;
   logic [WIDTH-1:0]   lo_reg, lo_next;

   logic               core_load;
   logic               core_step;
   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] fixed_product;
   logic               last_step;

   // Signed operands become magnitudes; the most negative value maps onto
   // 2^(WIDTH-1), which is representable in the unsigned datapath.
   always_comb begin
      mag1 = (signed_i && src1_i[WIDTH-1]) ? -src1_i : src1_i;
      mag2 = (signed_i && src2_i[WIDTH-1]) ? -src2_i : src2_i;
   end

   assign fixed_product = neg_reg ? -product : product;

   mul_shift_add_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .load      (core_load),
      .step      (core_step),
      .mcand_in  (mag1),
      .mplier_in (mag2),
      .product   (product),
      .last_step (last_step)
   );

   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      neg_next   = neg_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      core_load  = 1'b0;
      core_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            // A write in the start cycle still lands; the product overwrites it later.
            if (hi_we_i) hi_next = wdata_i;
            if (lo_we_i) lo_next = wdata_i;
            if (start_i) begin
               core_load  = 1'b1;
               neg_next   = signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
               state_next = RUN;
            end
         end
         RUN: begin
            core_step = 1'b1;
            if (last_step) state_next = FIX;
         end
         FIX: begin
            {hi_next, lo_next} = fixed_product;
            done_next          = 1'b1;
            state_next         = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         neg_reg   <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         neg_reg   <= neg_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   assign busy_o = busy_reg;
   assign done_o = done_reg;
   assign hi_o   = hi_reg;
   assign lo_o   = lo_reg;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_hilo_unit
// Self-checking bench: directed corner cases plus randomized multiplies and
// mthi/mtlo writes, compared against a plain-arithmetic HI/LO model.
// ---------------------------------------------------------------------------
module tb_mul_hilo_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        signed_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic        hi_we_i;
   logic        lo_we_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference HI/LO contents
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk_i = ~clk_i;

   mul_hilo_unit dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .signed_i (signed_i),
      .src1_i   (src1_i),
      .src2_i   (src2_i),
      .hi_we_i  (hi_we_i),
      .lo_we_i  (lo_we_i),
      .wdata_i  (wdata_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".hi"}, 64'(hi_o), 64'(hi_m));
      check({tag, ".lo"}, 64'(lo_o), 64'(lo_m));
   endtask

   // Expected 64-bit product from plain arithmetic.
   function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = 64'(a);
      ub = 64'(b);
      return ua * ub;
   endfunction

   // One multiply. disturb_at: sample index at which a stray start + mthi is
   // driven while busy. abort_at: sample index at which reset is pulsed.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int disturb_at, input int abort_at, input string tag);
      logic [63:0] exp_p;
      int          busy_cnt;
      int          done_cnt;
      int          lat;
      exp_p = ref_product(a, b, sgn);
      @(negedge clk_i);
      start_i  = 1'b1;
      signed_i = sgn;
      src1_i   = a;
      src2_i   = b;
      @(posedge clk_i);                 // start sampled here (E0)
      busy_cnt = 0;
      done_cnt = 0;
      lat      = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk_i);              // sample k reflects edge Ek
         if (k == abort_at) begin
            rst_i = 1'b0;
            #1;
            check({tag, ".abort_busy"}, 64'(busy_o), 64'd0);
            check({tag, ".abort_done"}, 64'(done_o), 64'd0);
            hi_m = '0;
            lo_m = '0;
            check_outputs({tag, ".abort"});
            start_i = 1'b0;
            @(negedge clk_i);
            rst_i = 1'b1;
            $display("mul %s %h * %h aborted by reset at cycle %0d", tag, a, b, k);
            return;
         end
         if (busy_o) busy_cnt++;
         if (done_o) begin
            done_cnt++;
            if (lat < 0) lat = k;
         end
         start_i  = (k == disturb_at);
         hi_we_i  = (k == disturb_at);
         wdata_i  = 32'h0000DEAD;
         src1_i   = (k == disturb_at) ? 32'd1 : $urandom;
         src2_i   = (k == disturb_at) ? 32'd1 : $urandom;
         if (lat >= 0 && k == lat + 2) break;
      end
      start_i = 1'b0;
      hi_we_i = 1'b0;
      {hi_m, lo_m} = exp_p;
      check({tag, ".latency"}, 64'(lat), 64'd33);
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
      check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
      check_outputs(tag);
      $display("mul %s %s %h * %h -> hi=%h lo=%h lat=%0d", tag, sgn ? "s" : "u",
               a, b, hi_o, lo_o, lat);
   endtask

   task automatic do_write(input logic sel_hi, input logic [31:0] data, input string tag);
      @(negedge clk_i);
      hi_we_i = sel_hi;
      lo_we_i = !sel_hi;
      wdata_i = data;
      @(posedge clk_i);
      @(negedge clk_i);
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      if (sel_hi) hi_m = data;
      else        lo_m = data;
      check_outputs(tag);
      $display("%s %h -> hi=%h lo=%h", sel_hi ? "mthi" : "mtlo", data, hi_o, lo_o);
   endtask

   initial begin
      rst_i    = 1'b0;
      start_i  = 1'b0;
      signed_i = 1'b0;
      src1_i   = '0;
      src2_i   = '0;
      hi_we_i  = 1'b0;
      lo_we_i  = 1'b0;
      wdata_i  = '0;
      repeat (3) @(negedge clk_i);
      check("reset.busy", 64'(busy_o), 64'd0);
      check("reset.done", 64'(done_o), 64'd0);
      check_outputs("reset");
      rst_i = 1'b1;

      do_mul(32'd3,          32'd5,          1'b1, -1, -1, "s3x5");
      do_mul(32'hFFFFFFFE,   32'h00000003,   1'b1, -1, -1, "sm2x3");
      check("sm2x3.hi_const", 64'(hi_o), 64'h00000000FFFFFFFF);
      check("sm2x3.lo_const", 64'(lo_o), 64'h00000000FFFFFFFA);
      do_mul(32'h80000000,   32'h80000000,   1'b1, -1, -1, "smin2");
      check("smin2.hi_const", 64'(hi_o), 64'h0000000040000000);
      do_mul(32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, -1, -1, "umax2");
      check("umax2.hi_const", 64'(hi_o), 64'h00000000FFFFFFFE);
      check("umax2.lo_const", 64'(lo_o), 64'h0000000000000001);
      do_mul(32'd7,          32'd9,          1'b1, 10, -1, "busy_ignore");
      check("busy_ignore.lo_const", 64'(lo_o), 64'd63);

      do_write(1'b1, 32'h12345678, "mthi");
      do_write(1'b0, 32'h9ABCDEF0, "mtlo");
      do_mul(32'd0,          32'hFFFFFFFF,   1'b1, -1, -1, "s0xm1");

      do_mul(32'h00001234,   32'h00005678,   1'b0, -1, 15, "abort");
      do_mul(32'd2,          32'd2,          1'b1, -1, -1, "after_abort");
      check("after_abort.lo_const", 64'(lo_o), 64'd4);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0)
            do_write(1'($urandom_range(0, 1)), $urandom, $sformatf("rnd%0d.wr", i));
         do_mul(a, b, 1'($urandom_range(0, 1)), -1, -1, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
